// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: op codes, FSM states and the
// multi-cycle op classifier. ALU_MULDIV_EN selects whether MUL/DIVU/REMU
// are real multi-cycle ops (see alu_mc).
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_XOR  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_MUL  = 4'd10,
    ALU_DIVU = 4'd11,
    ALU_REMU = 4'd12
  } alu_fun_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // True for the ops handled by the iterative engine.
  function automatic logic is_multicycle(input logic [3:0] fun);
    return (fun == ALU_MUL) || (fun == ALU_DIVU) || (fun == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply / unsigned divide engine, one bit per cycle.
// Only instantiated by alu_mc when ALU_MULDIV_EN is defined.
// The three working registers are shared between the two algorithms:
//   acc_reg : product accumulator (MUL) / partial remainder (DIVU/REMU)
//   opa_reg : shifting multiplicand (MUL) / dividend shifting into quotient
//   opb_reg : shifting multiplier (MUL)   / divisor
// done pulses for one cycle, one cycle after the final iteration.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [3:0]      fun,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN + 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             done_reg;
  logic [3:0]       fun_reg;
  logic [XLEN-1:0]  acc_reg, opa_reg, opb_reg;
  logic [XLEN-1:0]  acc_next, opa_next, opb_next;
  logic [XLEN:0]    div_tmp;
  logic [XLEN-1:0]  div_diff;
  logic             div_ge;

  // One iteration step of whichever algorithm is running.
  always_comb begin
    div_tmp  = {acc_reg, opa_reg[XLEN-1]};
    div_diff = div_tmp[XLEN-1:0] - opb_reg;
    div_ge   = (div_tmp >= {1'b0, opb_reg});
    if (fun_reg == ALU_MUL) begin
      acc_next = opb_reg[0] ? (acc_reg + opa_reg) : acc_reg;
      opa_next = {opa_reg[XLEN-2:0], 1'b0};
      opb_next = {1'b0, opb_reg[XLEN-1:1]};
    end else begin
      // Restoring division; divisor 0 naturally yields all-ones / A.
      acc_next = div_ge ? div_diff : div_tmp[XLEN-1:0];
      opa_next = {opa_reg[XLEN-2:0], div_ge};
      opb_next = opb_reg;
    end
  end

  // Load on start, then iterate while the counter is non-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      done_reg <= 1'b0;
      fun_reg  <= ALU_ADD;
      acc_reg  <= '0;
      opa_reg  <= '0;
      opb_reg  <= '0;
    end else if (flush) begin
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else if (start) begin
      cnt_reg  <= CNT_W'(XLEN);
      done_reg <= 1'b0;
      fun_reg  <= fun;
      acc_reg  <= '0;
      opa_reg  <= a;
      opb_reg  <= b;
    end else if (cnt_reg != '0) begin
      cnt_reg  <= cnt_reg - CNT_W'(1);
      done_reg <= (cnt_reg == CNT_W'(1));
      acc_reg  <= acc_next;
      opa_reg  <= opa_next;
      opb_reg  <= opb_next;
    end else begin
      done_reg <= 1'b0;
    end
  end

  // Pick the finished quantity for the requested op.
  always_comb begin
    case (fun_reg)
      ALU_MUL:  result = acc_reg;
      ALU_DIVU: result = opa_reg;
      default:  result = acc_reg;
    endcase
  end

  assign done = done_reg;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on request and result.
// Define ALU_MULDIV_EN to build the iterative MUL/DIVU/REMU engine;
// without it, op codes 10-12 complete in one cycle as illegal.
module alu_mc
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            alu_sel_i,
  input  logic [3:0]      alu_fun_i,
  input  logic [XLEN-1:0] reg_a_i,
  input  logic [XLEN-1:0] reg_b_i,
  input  logic [XLEN-1:0] imm_ext_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] alu_out_o,
  output logic            illegal_o
);

  localparam int SHW = $clog2(XLEN);

  alu_state_e      state_reg, state_next;
  logic [XLEN-1:0] result_reg, result_next;
  logic            illegal_reg, illegal_next;
  logic [XLEN-1:0] opb;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] sc_result;
  logic            sc_illegal;
  logic            accept;
  logic            mdu_start;
  logic            mdu_done;
  logic [XLEN-1:0] mdu_result;

  assign opb     = alu_sel_i ? imm_ext_i : reg_b_i;
  assign shamt   = opb[SHW-1:0];
  // Flush blocks accept; DONE can hand over to a new request in one cycle.
  assign ready_o = !flush_i &&
                   ((state_reg == ST_IDLE) || ((state_reg == ST_DONE) && ready_i));
  assign accept  = valid_i && ready_o;

  // Single-cycle datapath; anything not listed is illegal here.
  always_comb begin
    sc_result  = '0;
    sc_illegal = 1'b0;
    case (alu_fun_i)
      ALU_ADD:  sc_result = reg_a_i + opb;
      ALU_SUB:  sc_result = reg_a_i - opb;
      ALU_AND:  sc_result = reg_a_i & opb;
      ALU_XOR:  sc_result = reg_a_i ^ opb;
      ALU_OR:   sc_result = reg_a_i | opb;
      ALU_SLL:  sc_result = reg_a_i << shamt;
      ALU_SRL:  sc_result = reg_a_i >> shamt;
      ALU_SRA:  sc_result = $unsigned($signed(reg_a_i) >>> shamt);
      ALU_SLT:  sc_result = {{(XLEN-1){1'b0}}, $signed(reg_a_i) < $signed(opb)};
      ALU_SLTU: sc_result = {{(XLEN-1){1'b0}}, reg_a_i < opb};
      default:  sc_illegal = 1'b1;
    endcase
  end

`ifdef ALU_MULDIV_EN
  alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .start  (mdu_start),
    .flush  (flush_i),
    .fun    (alu_fun_i),
    .a      (reg_a_i),
    .b      (opb),
    .done   (mdu_done),
    .result (mdu_result)
  );
`else
  assign mdu_done   = 1'b0;
  assign mdu_result = '0;
`endif

  // FSM next state and result capture; flush overrides everything.
  always_comb begin
    state_next   = state_reg;
    result_next  = result_reg;
    illegal_next = illegal_reg;
    mdu_start    = 1'b0;
    if (flush_i) begin
      state_next   = ST_IDLE;
      result_next  = '0;
      illegal_next = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
`ifdef ALU_MULDIV_EN
            if (is_multicycle(alu_fun_i)) begin
              state_next = ST_BUSY;
              mdu_start  = 1'b1;
            end else begin
              state_next   = ST_DONE;
              result_next  = sc_result;
              illegal_next = sc_illegal;
            end
`else
            state_next   = ST_DONE;
            result_next  = sc_result;
            illegal_next = sc_illegal;
`endif
          end else if ((state_reg == ST_DONE) && ready_i) begin
            state_next = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (mdu_done) begin
            state_next   = ST_DONE;
            result_next  = mdu_result;
            illegal_next = 1'b0;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // State and registered result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= ST_IDLE;
      result_reg  <= '0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      result_reg  <= result_next;
      illegal_reg <= illegal_next;
    end
  end

  assign valid_o   = (state_reg == ST_DONE);
  assign alu_out_o = result_reg;
  assign illegal_o = illegal_reg;

endmodule

// File: tb/tb_alu_mc.sv
// Directed testbench for alu_mc (XLEN = 32). MUL/DIVU/REMU vectors run only
// when ALU_MULDIV_EN is defined; otherwise op 10 is checked as illegal.
module tb_alu_mc;

  logic        clk;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic        alu_sel_i;
  logic [3:0]  alu_fun_i;
  logic [31:0] reg_a_i;
  logic [31:0] reg_b_i;
  logic [31:0] imm_ext_i;
  logic        flush_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] alu_out_o;
  logic        illegal_o;

  int n_checks = 0;
  int n_errors = 0;

  alu_mc #(.XLEN(32)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .alu_sel_i (alu_sel_i),
    .alu_fun_i (alu_fun_i),
    .reg_a_i   (reg_a_i),
    .reg_b_i   (reg_b_i),
    .imm_ext_i (imm_ext_i),
    .flush_i   (flush_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .alu_out_o (alu_out_o),
    .illegal_o (illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, ".valid"}, 32'(valid_o), 32'd0);
    check_eq({tag, ".out"}, alu_out_o, 32'd0);
    check_eq({tag, ".illegal"}, 32'(illegal_o), 32'd0);
    check_eq({tag, ".ready"}, 32'(ready_o), 32'd1);
  endtask

  // Issue one request at a negedge, wait for the result, check it, consume it.
  task automatic do_op(input string tag, input logic [3:0] fun, input logic sel,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic [31:0] exp_out, input logic exp_ill, input int exp_lat);
    int   lat;
    logic ready_in_busy;
    valid_i   = 1'b1;
    alu_fun_i = fun;
    alu_sel_i = sel;
    reg_a_i   = a;
    reg_b_i   = b;
    imm_ext_i = imm;
    #1;
    check_eq({tag, ".accept"}, 32'(ready_o), 32'd1);
    @(negedge clk);
    // Scramble inputs: operands were latched on accept.
    valid_i   = 1'b0;
    reg_a_i   = 32'hDEAD_BEEF;
    reg_b_i   = 32'h1234_5678;
    imm_ext_i = 32'hCAFE_F00D;
    alu_fun_i = 4'd0;
    lat = 1;
    ready_in_busy = 1'b0;
    while (!valid_o && lat < 100) begin
      if (ready_o) ready_in_busy = 1'b1;
      @(negedge clk);
      lat++;
    end
    check_eq({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, ".out"}, alu_out_o, exp_out);
    check_eq({tag, ".illegal"}, 32'(illegal_o), 32'(exp_ill));
    if (exp_lat > 1) check_eq({tag, ".busy_ready"}, 32'(ready_in_busy), 32'd0);
    $display("txn %s fun=%0d a=%h b=%h -> out=%h ill=%0d lat=%0d",
             tag, fun, a, sel ? imm : b, alu_out_o, illegal_o, lat);
    @(negedge clk);
  endtask

  initial begin
    logic saw_valid;
    rst_ni    = 1'b0;
    valid_i   = 1'b0;
    alu_sel_i = 1'b0;
    alu_fun_i = 4'd0;
    reg_a_i   = '0;
    reg_b_i   = '0;
    imm_ext_i = '0;
    flush_i   = 1'b0;
    ready_i   = 1'b1;
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    check_reset_vals("reset");

    // Single-cycle ops.
    do_op("add_imm", 4'd0, 1'b1, 32'h7FFF_FFFF, 32'h5555_5555, 32'h0000_0001, 32'h8000_0000, 1'b0, 1);
    do_op("sub",  4'd1, 1'b0, 32'd5, 32'd7, 32'd0, 32'hFFFF_FFFE, 1'b0, 1);
    do_op("and",  4'd2, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'hF000_F000, 1'b0, 1);
    do_op("xor",  4'd3, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'h0FF0_0FF0, 1'b0, 1);
    do_op("or",   4'd4, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'hFFF0_FFF0, 1'b0, 1);
    do_op("sll",  4'd5, 1'b0, 32'd1, 32'h0000_0021, 32'd0, 32'd2, 1'b0, 1);
    do_op("srl",  4'd6, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 32'h0800_0000, 1'b0, 1);
    do_op("sra",  4'd7, 1'b0, 32'h8000_0000, 32'h0000_0024, 32'd0, 32'hF800_0000, 1'b0, 1);
    do_op("slt",  4'd8, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd1, 1'b0, 1);
    do_op("sltu", 4'd9, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 1'b0, 1);
    do_op("ill14", 4'd14, 1'b0, 32'd3, 32'd4, 32'd0, 32'd0, 1'b1, 1);

`ifdef ALU_MULDIV_EN
    do_op("mul",    4'd10, 1'b0, 32'h0001_0003, 32'h0002_0005, 32'd0, 32'h000B_000F, 1'b0, 33);
    do_op("divu",   4'd11, 1'b0, 32'd100, 32'd7, 32'd0, 32'd14, 1'b0, 33);
    do_op("remu",   4'd12, 1'b0, 32'd100, 32'd7, 32'd0, 32'd2, 1'b0, 33);
    do_op("divu0",  4'd11, 1'b0, 32'd5, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 33);
    do_op("remu0",  4'd12, 1'b0, 32'd5, 32'd0, 32'd0, 32'd5, 1'b0, 33);
`else
    do_op("mul_ill", 4'd10, 1'b0, 32'h0001_0003, 32'h0002_0005, 32'd0, 32'd0, 1'b1, 1);
`endif

    // Streaming: ten back-to-back ADDs, one result per cycle.
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) begin
        check_eq($sformatf("stream%0d.valid", k - 1), 32'(valid_o), 32'd1);
        check_eq($sformatf("stream%0d.out", k - 1), alu_out_o, 32'(k - 1 + 100));
        $display("txn stream%0d out=%h", k - 1, alu_out_o);
      end
      if (k < 10) begin
        valid_i = 1'b1; alu_fun_i = 4'd0; alu_sel_i = 1'b0;
        reg_a_i = 32'(k); reg_b_i = 32'd100;
        #1;
        check_eq($sformatf("stream%0d.ready", k), 32'(ready_o), 32'd1);
      end else begin
        valid_i = 1'b0;
      end
      @(negedge clk);
    end
    @(negedge clk);

    // Back-pressure: result held 3 cycles, pending request not accepted.
    ready_i = 1'b0;
    valid_i = 1'b1; alu_fun_i = 4'd0; alu_sel_i = 1'b0; reg_a_i = 32'd5; reg_b_i = 32'd6;
    @(negedge clk);
    reg_a_i = 32'd1000;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq($sformatf("hold%0d.valid", k), 32'(valid_o), 32'd1);
      check_eq($sformatf("hold%0d.out", k), alu_out_o, 32'd11);
      check_eq($sformatf("hold%0d.ready", k), 32'(ready_o), 32'd0);
      $display("txn hold%0d out=%h", k, alu_out_o);
      @(negedge clk);
    end
    ready_i = 1'b1;
    #1;
    check_eq("hold_release.ready", 32'(ready_o), 32'd1);
    @(negedge clk);
    valid_i = 1'b0;
    check_eq("hold_next.out", alu_out_o, 32'd1006);
    $display("txn hold_next out=%h", alu_out_o);
    @(negedge clk);

    // Flush discards a DONE result and blocks accept in the flush cycle.
    ready_i = 1'b0;
    valid_i = 1'b1; alu_fun_i = 4'd0; reg_a_i = 32'd1; reg_b_i = 32'd2;
    @(negedge clk);
    check_eq("flush_pre.out", alu_out_o, 32'd3);
    flush_i = 1'b1; ready_i = 1'b1; reg_a_i = 32'd10; reg_b_i = 32'd20;
    #1;
    check_eq("flush.ready", 32'(ready_o), 32'd0);
    @(negedge clk);
    flush_i = 1'b0; valid_i = 1'b0;
    check_eq("flush.valid", 32'(valid_o), 32'd0);
    $display("txn flush_done valid=%0d", valid_o);
    @(negedge clk);
    check_eq("flush_after.valid", 32'(valid_o), 32'd0);

`ifdef ALU_MULDIV_EN
    // Flush in the 10th BUSY cycle: no result ever appears.
    valid_i = 1'b1; alu_fun_i = 4'd11; reg_a_i = 32'd100; reg_b_i = 32'd7;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check_eq("busy_flush.ready", 32'(ready_o), 32'd1);
    saw_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (valid_o) saw_valid = 1'b1;
      @(negedge clk);
    end
    check_eq("busy_flush.valid", 32'(saw_valid), 32'd0);
    $display("txn busy_flush saw_valid=%0d", saw_valid);

    // Reset in the middle of a DIVU.
    valid_i = 1'b1; alu_fun_i = 4'd11; reg_a_i = 32'd100; reg_b_i = 32'd7;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (5) @(negedge clk);
    rst_ni = 1'b0;
    #1;
    check_reset_vals("rst_divu");
    @(negedge clk);
    rst_ni = 1'b1;
    saw_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (valid_o) saw_valid = 1'b1;
      @(negedge clk);
    end
    check_eq("rst_divu.noresult", 32'(saw_valid), 32'd0);
    $display("txn rst_divu saw_valid=%0d", saw_valid);
`endif

    // Reset while an illegal result is held in DONE.
    ready_i = 1'b0;
    valid_i = 1'b1; alu_fun_i = 4'd15; reg_a_i = 32'd1; reg_b_i = 32'd1;
    @(negedge clk);
    valid_i = 1'b0;
    check_eq("rst_done.pre_illegal", 32'(illegal_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check_reset_vals("rst_done");
    $display("txn rst_done valid=%0d ill=%0d", valid_o, illegal_o);
    @(negedge clk);
    rst_ni = 1'b1;
    ready_i = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the integer execute stage, successor to the single-cycle add/sub/logic ALU. Adds shifts, signed/unsigned compare and an optional iterative multiply/divide unit. Operand select (register or immediate) is kept. Operations are accepted and returned over valid/ready handshakes, so the stage stalls cleanly while long operations run.

## Interface
- XLEN, 32, datapath width; power of two, at least 8.
- SHW, $clog2(XLEN), shift-amount width; derived, not overridable.

- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- valid_i  in  1  request valid
- ready_o  out  1  request accepted when valid_i & ready_o
- alu_sel_i  in  1  1 = operand B from imm_ext_i, 0 = from reg_b_i
- alu_fun_i  in  4  operation code
- reg_a_i  in  XLEN  operand A
- reg_b_i  in  XLEN  operand B (register)
- imm_ext_i  in  XLEN  operand B (sign-extended immediate)
- flush_i  in  1  abort the in-flight operation
- valid_o  out  1  result valid
- ready_i  in  1  consumer accepts result when valid_o & ready_i
- alu_out_o  out  XLEN  result
- illegal_o  out  1  qualifies alu_out_o; 1 = unsupported fun code

## Operation
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 XOR, 4 OR
  - 5 SLL, 6 SRL, 7 SRA: shift amount = B[SHW-1:0]
  - 8 SLT (signed), 9 SLTU: result is 1 or 0, zero-extended
  - 10 MUL: low XLEN bits of A*B
  - 11 DIVU, 12 REMU
  - 13–15: illegal
- Operands A and B are latched on accept. Later input changes have no effect.
- Arithmetic wraps modulo 2^XLEN. No overflow flag.
- DIVU by 0 gives all ones. REMU by 0 gives A.
- An illegal code gives alu_out_o = 0 and illegal_o = 1. No X is ever driven.
- FSM states: IDLE, BUSY, DONE.
  - IDLE → DONE on accept of a single-cycle op. The result is registered.
  - IDLE → BUSY on accept of MUL/DIVU/REMU. The iteration counter is loaded with XLEN.
  - BUSY: one bit per cycle (shift-add for MUL, restoring shift-subtract for DIVU/REMU). The counter decrements each cycle. At counter = 1 → DONE.
  - DONE: valid_o = 1, outputs held stable until ready_i. On ready_i, return to IDLE, or go directly to DONE/BUSY if a new request is accepted in the same cycle.
- ready_o = (state == IDLE) | (state == DONE & ready_i). This is a combinational ready_i → ready_o path and gives one single-cycle op per clock.
- flush_i has priority over everything:
  - Any state → IDLE next cycle. valid_o drops, and no request is accepted in a flush cycle (ready_o = 0).
  - A result in DONE is discarded.

## Timing
- Reset values:
  - state IDLE, counter 0
  - valid_o 0, alu_out_o 0, illegal_o 0
  - ready_o 1 (combinational from state)
- Reset asserted mid-operation aborts immediately. No result is produced.
- Single-cycle ops: valid_o rises 1 cycle after accept.
- MUL/DIVU/REMU: valid_o rises XLEN+1 cycles after accept (33 at XLEN=32).
- Back-pressure: valid_o, alu_out_o and illegal_o stay constant while valid_o & !ready_i.
- valid_i while BUSY is not accepted (ready_o = 0). The requester must hold its request.

## Configuration
- ALU_MULDIV_EN defined: op codes 10–12 are implemented as above.
- ALU_MULDIV_EN undefined:
  - Op codes 10–12 are illegal and complete in 1 cycle (alu_out_o = 0, illegal_o = 1).
  - The BUSY state, counter and multiplier/divider logic are not built.

## Structure
- Package alu_pkg:
  - alu_fun_e enum with the op codes above
  - alu_state_e (IDLE/BUSY/DONE)
  - an is_multicycle() helper function
- Sub-module alu_muldiv_iter:
  - Iterative engine holding the accumulator, partial remainder and quotient registers, plus the counter.
  - start/done/flush interface.
  - Instantiated only under ALU_MULDIV_EN.
- Single-cycle datapath and FSM stay in alu_mc.

## Test plan (XLEN = 32)
- ADD, alu_sel_i = 1, A = 0x7FFFFFFF, imm = 0x00000001 → valid_o next cycle, alu_out_o = 0x80000000, illegal_o = 0.
- SRA: A = 0x80000000, B = 0x00000024 (shift amount 4) → 0xF8000000. SLT with A = 0xFFFFFFFF, B = 0 → 1; SLTU with the same operands → 0.
- MUL: A = 0x00010003, B = 0x00020005 → alu_out_o = 0x000B000F, valid_o rises exactly 33 cycles after accept, ready_o = 0 throughout.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
- Streaming: ten back-to-back ADDs with ready_i = 1 give ten results on ten consecutive cycles. With ready_i held 0 for 3 cycles, the output is held stable and no extra accept occurs.
- Abort cases: flush_i in the 10th BUSY cycle → IDLE, no valid_o. rst_ni low mid-DIVU → all outputs at reset values. fun = 14 → alu_out_o = 0, illegal_o = 1. Without ALU_MULDIV_EN, fun = 10 → illegal_o = 1 after 1 cycle.
